// File: rtl/apb_pkg.sv
// Shared types and default widths for the APB master slice.
package apb_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        DONE
    } apb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin select: returns the first set request at or
// above rr_ptr_i, wrapping around, plus a flag saying whether any request is set.
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   rr_ptr_i,
    output logic               any_o,
    output logic [IDX_W-1:0]   grant_o
);

    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] cand;

    // Walk from the farthest offset down so the closest match to rr_ptr_i wins.
    always_comb begin
        any_o   = 1'b0;
        grant_o = '0;
        sum     = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            sum = {1'b0, rr_ptr_i} + (IDX_W + 1)'(i);
            if (sum >= (IDX_W + 1)'(NUM_REQ)) begin
                sum = sum - (IDX_W + 1)'(NUM_REQ);
            end
            cand = sum[IDX_W-1:0];
            if (req_i[cand]) begin
                any_o   = 1'b1;
                grant_o = cand;
            end
        end
    end

endmodule

// File: rtl/apb_master_arb.sv
// Multi-requester APB master: round-robin grant, SETUP/ACCESS sequencing, done pulse.
// Optional ACCESS-phase timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_arb
    import apb_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int DATA_W         = DEFAULT_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                      pclk,
    input  logic                      prst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_write,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        done,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic                      psel,
    output logic                      penable,
    output logic                      pwrite,
    output logic [ADDR_W-1:0]         paddr,
    output logic [DATA_W-1:0]         pwdata,
    input  logic [DATA_W-1:0]         prdata,
    input  logic                      pready,
    input  logic                      pslverr
);

    localparam int IDX_W = $clog2(NUM_REQ);

    apb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;
    logic              arb_any;
    logic [IDX_W-1:0]  arb_idx;
    logic              timeout;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i    (req),
        .rr_ptr_i (rr_ptr_q),
        .any_o    (arb_any),
        .grant_o  (arb_idx)
    );

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // This ACCESS cycle is the TIMEOUT_CYCLES-th one without pready.
    assign timeout = !pready && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == SETUP) begin
            cnt_d = '0;
        end else if (state_q == ACCESS && !pready) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        pwrite_d = pwrite_q;
        paddr_d  = paddr_q;
        pwdata_d = pwdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    state_d  = SETUP;
                    grant_d  = arb_idx;
                    pwrite_d = req_write[arb_idx];
                    paddr_d  = req_addr[arb_idx*ADDR_W +: ADDR_W];
                    pwdata_d = req_wdata[arb_idx*DATA_W +: DATA_W];
                end
            end
            SETUP: begin
                state_d = ACCESS;
            end
            ACCESS: begin
                // A pready in the timeout cycle still completes normally.
                if (pready) begin
                    state_d = DONE;
                    rdata_d = pwrite_q ? '0 : prdata;
                    err_d   = pslverr;
                end else if (timeout) begin
                    state_d = DONE;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            DONE: begin
                state_d  = IDLE;
                rr_ptr_d = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (prst) begin
            state_q  <= IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            pwrite_q <= 1'b0;
            paddr_q  <= '0;
            pwdata_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            pwrite_q <= pwrite_d;
            paddr_q  <= paddr_d;
            pwdata_q <= pwdata_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        done = '0;
        if (state_q == DONE) begin
            done[grant_q] = 1'b1;
        end
    end

    assign psel      = (state_q == SETUP) || (state_q == ACCESS);
    assign penable   = (state_q == ACCESS);
    assign pwrite    = pwrite_q;
    assign paddr     = paddr_q;
    assign pwdata    = pwdata_q;
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule

// File: tb/tb_apb_master_arb.sv
// Self-checking bench for apb_master_arb with a 16-entry APB slave model and a
// completion scoreboard; define APB_TIMEOUT_EN to also exercise the timeout path.
module tb_apb_master_arb;

    localparam int NUM_REQ    = 2;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 8;
    localparam int TB_TIMEOUT = 4;
`ifdef APB_TIMEOUT_EN
    localparam int WAIT_N = 3;
`else
    localparam int WAIT_N = 5;
`endif

    logic                      pclk;
    logic                      prst;
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        reqWrite;
    logic [NUM_REQ*ADDR_W-1:0] reqAddr;
    logic [NUM_REQ*DATA_W-1:0] reqWdata;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         rspRdata;
    logic                      rspErr;
    logic                      psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_W-1:0]         paddr;
    logic [DATA_W-1:0]         pwdata;
    logic [DATA_W-1:0]         prdata;
    logic                      pready;
    logic                      pslverr;

    int checks = 0;
    int errors = 0;
    bit monEn  = 0;

    typedef struct {
        int         idx;
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    exp_t       sbQ[$];
    logic [7:0] refMem [16];

    apb_master_arb #(
        .NUM_REQ        (NUM_REQ),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TB_TIMEOUT)
    ) dut (
        .pclk      (pclk),
        .prst      (prst),
        .req       (req),
        .req_write (reqWrite),
        .req_addr  (reqAddr),
        .req_wdata (reqWdata),
        .done      (done),
        .rsp_rdata (rspRdata),
        .rsp_err   (rspErr),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    // APB slave: 16 registers, out-of-range addresses error, pready after waitTarget ACCESS cycles.
    logic [7:0] slaveMem [16];
    int         waitTarget = 0;
    int         waitCnt    = 0;
    logic       inRange;

    assign inRange = (paddr < 32'd16);
    assign pready  = (waitCnt >= waitTarget);
    assign prdata  = inRange ? slaveMem[paddr[3:0]] : 8'h00;
    assign pslverr = psel && penable && !inRange;

    always @(posedge pclk) begin
        if (prst) begin
            waitCnt <= 0;
        end else if (psel && penable) begin
            if (pready) begin
                waitCnt <= 0;
                if (pwrite && inRange) slaveMem[paddr[3:0]] <= pwdata;
            end else begin
                waitCnt <= waitCnt + 1;
            end
        end else begin
            waitCnt <= 0;
        end
    end

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge pclk) begin
        exp_t e;
        logic [NUM_REQ-1:0] expDone;
        if (monEn && done !== '0) begin
            checks++;
            if (sbQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done got=%b expected none", done);
            end else begin
                e = sbQ.pop_front();
                expDone = '0;
                expDone[e.idx] = 1'b1;
                if (done !== expDone) begin
                    errors++;
                    $display("[TB] FAIL done_vector got=%b expected=%b", done, expDone);
                end
                checks++;
                if (rspRdata !== e.rdata) begin
                    errors++;
                    $display("[TB] FAIL rsp_rdata got=%h expected=%h", rspRdata, e.rdata);
                end
                checks++;
                if (rspErr !== e.err) begin
                    errors++;
                    $display("[TB] FAIL rsp_err got=%b expected=%b", rspErr, e.err);
                end
            end
        end
    end

    task automatic predict(input int idx, input bit wr, input logic [31:0] addr,
                           input logic [7:0] wdata);
        exp_t e;
        e.idx = idx;
        if (addr >= 32'd16) begin
            e.err   = 1'b1;
            e.rdata = 8'h00;
        end else begin
            e.err = 1'b0;
            if (wr) begin
                refMem[addr[3:0]] = wdata;
                e.rdata = 8'h00;
            end else begin
                e.rdata = refMem[addr[3:0]];
            end
        end
        sbQ.push_back(e);
    endtask

    task automatic setCmd(input int idx, input bit wr, input logic [31:0] addr,
                          input logic [7:0] wdata);
        reqWrite[idx]                  = wr;
        reqAddr[idx*ADDR_W +: ADDR_W]  = addr;
        reqWdata[idx*DATA_W +: DATA_W] = wdata;
    endtask

    // One requester transaction, started from an IDLE-cycle negedge; checks phases and latency.
    task automatic doTxn(input int idx, input bit wr, input logic [31:0] addr,
                         input logic [7:0] wdata, input int expLat);
        int lat = 0;
        bit got = 0;
        setCmd(idx, wr, addr, wdata);
        req[idx] = 1'b1;
        while (!got && lat < 60) begin
            @(negedge pclk);
            lat++;
            if (lat == 1) begin
                checks++;
                if (psel !== 1'b1 || penable !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL setup_phase psel=%b penable=%b expected 1/0", psel, penable);
                end
            end
            if (lat >= 2 && lat < expLat) begin
                checks++;
                if (psel !== 1'b1 || penable !== 1'b1) begin
                    errors++;
                    $display("[TB] FAIL access_phase cyc=%0d psel=%b penable=%b expected 1/1",
                             lat, psel, penable);
                end
            end
            if (psel === 1'b1) begin
                checks++;
                if (paddr !== addr || pwrite !== wr || (wr && pwdata !== wdata)) begin
                    errors++;
                    $display("[TB] FAIL apb_cmd paddr=%h pwrite=%b pwdata=%h expected %h/%b/%h",
                             paddr, pwrite, pwdata, addr, wr, wdata);
                end
            end
            if (done[idx] === 1'b1) got = 1;
        end
        checks++;
        if (!got) begin
            errors++;
            $display("[TB] FAIL done_timeout req=%0d no done within %0d cycles", idx, lat);
        end else if (lat != expLat) begin
            errors++;
            $display("[TB] FAIL latency req=%0d got=%0d expected=%0d", idx, lat, expLat);
        end
        req[idx] = 1'b0;
        @(negedge pclk);
    endtask

    // Both requesters held high; expects `pulses` dones spaced 4 cycles apart.
    task automatic contend(input int pulses);
        int cyc  = 0;
        int last = 0;
        int n    = 0;
        req = 2'b11;
        while (n < pulses && cyc < 80) begin
            @(negedge pclk);
            cyc++;
            if (done !== '0) begin
                n++;
                if (n > 1) begin
                    checks++;
                    if (cyc - last != 4) begin
                        errors++;
                        $display("[TB] FAIL done_spacing got=%0d expected=4", cyc - last);
                    end
                end
                last = cyc;
            end
        end
        req = 2'b00;
        checks++;
        if (n != pulses) begin
            errors++;
            $display("[TB] FAIL contention_count got=%0d expected=%0d", n, pulses);
        end
        @(negedge pclk);
    endtask

    task automatic test_reset();
        prst = 1'b1;
        repeat (3) @(negedge pclk);
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || pwrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ctrl psel=%b penable=%b pwrite=%b expected 0", psel, penable, pwrite);
        end
        checks++;
        if (paddr !== '0 || pwdata !== '0) begin
            errors++;
            $display("[TB] FAIL reset_bus paddr=%h pwdata=%h expected 0", paddr, pwdata);
        end
        checks++;
        if (done !== '0 || rspRdata !== '0 || rspErr !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_rsp done=%b rdata=%h err=%b expected 0", done, rspRdata, rspErr);
        end
        prst = 1'b0;
        @(negedge pclk);
    endtask

    task automatic test_single_write();
        predict(0, 1'b1, 32'd3, 8'hA5);
        doTxn(0, 1'b1, 32'd3, 8'hA5, 3);
        checks++;
        if (slaveMem[3] !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL slave_mem3 got=%h expected=a5", slaveMem[3]);
        end
    endtask

    task automatic test_single_read();
        predict(1, 1'b0, 32'd3, 8'h00);
        doTxn(1, 1'b0, 32'd3, 8'h00, 3);
    endtask

    task automatic test_contention();
        setCmd(0, 1'b0, 32'd3, 8'h00);
        setCmd(1, 1'b1, 32'd9, 8'h5A);
        predict(0, 1'b0, 32'd3, 8'h00);
        predict(1, 1'b1, 32'd9, 8'h5A);
        predict(0, 1'b0, 32'd3, 8'h00);
        predict(1, 1'b1, 32'd9, 8'h5A);
        contend(4);
    endtask

    task automatic test_error();
        predict(0, 1'b0, 32'd20, 8'h00);
        doTxn(0, 1'b0, 32'd20, 8'h00, 3);
    endtask

    task automatic test_wait_states();
        waitTarget = WAIT_N;
        predict(0, 1'b1, 32'd7, 8'h3C);
        doTxn(0, 1'b1, 32'd7, 8'h3C, 3 + WAIT_N);
        waitTarget = 0;
    endtask

    task automatic test_reset_mid();
        int accessCyc = 0;
        int cyc = 0;
        waitTarget = 100;
        setCmd(0, 1'b1, 32'd8, 8'h77);
        req[0] = 1'b1;
        while (accessCyc < 3 && cyc < 20) begin
            @(negedge pclk);
            cyc++;
            if (penable === 1'b1) accessCyc++;
        end
        prst = 1'b1;
        @(negedge pclk);
        checks++;
        if (psel !== 1'b0 || penable !== 1'b0 || done !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset psel=%b penable=%b done=%b expected 0/0/00", psel, penable, done);
        end
        checks++;
        if (paddr !== '0 || pwdata !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset_bus paddr=%h pwdata=%h expected 0", paddr, pwdata);
        end
        prst = 1'b0;
        req = 2'b00;
        waitTarget = 0;
        repeat (4) @(negedge pclk);
        checks++;
        if (slaveMem[8] === 8'h77) begin
            errors++;
            $display("[TB] FAIL abandoned_write slave_mem8=%h expected not 77", slaveMem[8]);
        end
    endtask

    task automatic test_rr_after_reset();
        setCmd(0, 1'b0, 32'd9, 8'h00);
        setCmd(1, 1'b0, 32'd3, 8'h00);
        predict(0, 1'b0, 32'd9, 8'h00);
        predict(1, 1'b0, 32'd3, 8'h00);
        contend(2);
    endtask

`ifdef APB_TIMEOUT_EN
    task automatic test_timeout();
        exp_t e;
        waitTarget = 1000;
        e.idx = 1; e.rdata = 8'h00; e.err = 1'b1;
        sbQ.push_back(e);
        doTxn(1, 1'b0, 32'd3, 8'h00, 2 + TB_TIMEOUT);
        waitTarget = 0;
        predict(0, 1'b0, 32'd9, 8'h00);
        doTxn(0, 1'b0, 32'd9, 8'h00, 3);
    endtask
`endif

    initial begin
        prst     = 1'b1;
        req      = '0;
        reqWrite = '0;
        reqAddr  = '0;
        reqWdata = '0;
        test_reset();
        monEn = 1;
        test_single_write();
        test_single_read();
        test_contention();
        test_error();
        test_wait_states();
        test_reset_mid();
        test_rr_after_reset();
`ifdef APB_TIMEOUT_EN
        test_timeout();
`endif
        repeat (3) @(negedge pclk);
        checks++;
        if (sbQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_drain pending=%0d expected=0", sbQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
